// File: rtl/result_collector.sv
// Result collector: tracks issues into a fixed-latency upstream pipeline and
// captures their results into a FIFO, throttling issue so captures always have space.
module result_collector #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4,
    parameter int LAT    = 3,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(LAT + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    output logic              can_issue_o,
    input  logic [DWIDTH-1:0] res_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_data_o,
    output logic [CW-1:0]     count_o,
    output logic [IW-1:0]     inflight_o,
    output logic [15:0]       pop_cnt_o,
    output logic              err_o,
    output logic              ovf_o
);

    // Output handshake: an entry transfers on a rising edge where out_valid_o
    // and out_ready_i are both high; out_valid_o never depends on out_ready_i.

    logic [LAT-1:0]    vld_sr;
    logic [LAT-1:0]    sr_next;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              capture;
    logic              full;
    logic              pop;
    logic              wr;

    generate
        if (LAT == 1) begin : g_sr1
            assign sr_next = issue_i;
        end else begin : g_srn
            assign sr_next = {vld_sr[LAT-2:0], issue_i};
        end
    endgenerate

    always_comb begin
        inflight_o = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_o = inflight_o + IW'(vld_sr[i]);
        end
    end

    assign capture     = vld_sr[LAT-1];
    assign full        = (count_o == CW'(DEPTH));
    assign out_valid_o = (count_o != '0);
    assign out_data_o  = mem[rd_ptr];
    assign pop         = out_valid_o && out_ready_i;
    // A capture into a full FIFO still lands when the head leaves on the same edge.
    assign wr          = capture && (!full || pop);
    assign can_issue_o = (32'(count_o) + 32'(inflight_o)) < 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_o   <= '0;
            pop_cnt_o <= '0;
            err_o     <= 1'b0;
            ovf_o     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            vld_sr <= sr_next;
            if (wr) begin
                mem[wr_ptr] <= res_i;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                pop_cnt_o <= pop_cnt_o + 16'd1;
            end
            count_o <= count_o + CW'(wr) - CW'(pop);
            if (issue_i && !can_issue_o) begin
                err_o <= 1'b1;
            end
            if (capture && full && !pop) begin
                ovf_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: queue-based reference model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_result_collector;

    localparam int DWIDTH = 8;
    localparam int DEPTH  = 4;
    localparam int LAT    = 3;

    logic              clk;
    logic              rst;
    logic              issue_i;
    logic              can_issue_o;
    logic [DWIDTH-1:0] res_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DWIDTH-1:0] out_data_o;
    logic [2:0]        count_o;
    logic [1:0]        inflight_o;
    logic [15:0]       pop_cnt_o;
    logic              err_o;
    logic              ovf_o;

    int n_vec;
    int n_err;

    result_collector #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .issue_i(issue_i),
        .can_issue_o(can_issue_o),
        .res_i(res_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o(out_data_o),
        .count_o(count_o),
        .inflight_o(inflight_o),
        .pop_cnt_o(pop_cnt_o),
        .err_o(err_o),
        .ovf_o(ovf_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: pend_q holds edges elapsed since each outstanding issue
    int                pend_q[$];
    logic [DWIDTH-1:0] exp_q[$];
    logic              m_err;
    logic              m_ovf;
    logic [15:0]       m_pop;
    bit                model_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
            exp_q.delete();
            m_err      = 1'b0;
            m_ovf      = 1'b0;
            m_pop      = 16'd0;
            model_live = 1'b1;
        end else if (model_live) begin
            bit cap, pop, can;
            can = (exp_q.size() + pend_q.size()) < DEPTH;
            cap = (pend_q.size() > 0) && (pend_q[0] == LAT - 1);
            if (cap) void'(pend_q.pop_front());
            foreach (pend_q[i]) pend_q[i]++;
            if (issue_i) begin
                pend_q.push_back(0);
                if (!can) m_err = 1'b1;
            end
            pop = (exp_q.size() > 0) && out_ready_i;
            if (pop) begin
                void'(exp_q.pop_front());
                m_pop = m_pop + 16'd1;
            end
            if (cap) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(res_i);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (model_live) begin
            check("m_count", 32'(count_o), 32'(exp_q.size()));
            check("m_inflight", 32'(inflight_o), 32'(pend_q.size()));
            check("m_valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
            check("m_can_issue", 32'(can_issue_o), 32'((exp_q.size() + pend_q.size()) < DEPTH));
            check("m_err", 32'(err_o), 32'(m_err));
            check("m_ovf", 32'(ovf_o), 32'(m_ovf));
            check("m_pop_cnt", 32'(pop_cnt_o), 32'(m_pop));
            if (exp_q.size() != 0) check("m_data", 32'(out_data_o), 32'(exp_q[0]));
        end
    end

    // driver tasks: inputs change 2 time units after the active edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        issue_i     = 1'b0;
        out_ready_i = 1'b0;
        res_i       = '0;
        step();
        rst = 1'b0;
    endtask

    logic [7:0] vals[4];

    task automatic fill4();
        for (int e = 0; e < 7; e++) begin
            issue_i = (e < 4);
            res_i   = (e >= 3) ? vals[e-3] : 8'h00;
            step();
            if (e == 3) check("fill_can_issue", 32'(can_issue_o), 32'd0);
        end
        issue_i = 1'b0;
        res_i   = '0;
        check("fill_count", 32'(count_o), 32'd4);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vals  = '{8'h11, 8'h22, 8'h33, 8'h44};

        // reset state
        reset_dut();
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_can_issue", 32'(can_issue_o), 32'd1);
        check("rst_data", 32'(out_data_o), 32'd0);
        check("rst_pop_cnt", 32'(pop_cnt_o), 32'd0);
        check("rst_flags", 32'({err_o, ovf_o}), 32'd0);

        // single issue
        issue_i = 1'b1;
        step();
        check("single_inflight0", 32'(inflight_o), 32'd1);
        issue_i = 1'b0;
        step();
        check("single_inflight1", 32'(inflight_o), 32'd1);
        step();
        check("single_inflight2", 32'(inflight_o), 32'd1);
        check("single_no_bypass", 32'(out_valid_o), 32'd0);
        res_i = 8'h2A;
        step();
        res_i = '0;
        check("single_inflight3", 32'(inflight_o), 32'd0);
        check("single_valid", 32'(out_valid_o), 32'd1);
        check("single_data", 32'(out_data_o), 32'h2A);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("single_popped", 32'(count_o), 32'd0);
        check("single_pop_cnt", 32'(pop_cnt_o), 32'd1);

        // back-to-back, no drain, then ordered pops
        reset_dut();
        fill4();
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b2b_order", 32'(out_data_o), 32'(vals[i]));
            step();
        end
        out_ready_i = 1'b0;
        check("b2b_empty", 32'(out_valid_o), 32'd0);

        // full with simultaneous capture and pop
        reset_dut();
        fill4();
        issue_i = 1'b1;
        step();
        issue_i = 1'b0;
        check("viol_err", 32'(err_o), 32'd1);
        step();
        step();
        res_i       = 8'h55;
        out_ready_i = 1'b1;
        step();
        res_i       = '0;
        out_ready_i = 1'b0;
        check("full_pop_count", 32'(count_o), 32'd4);
        check("full_pop_ovf", 32'(ovf_o), 32'd0);
        check("full_pop_head", 32'(out_data_o), 32'h22);

        // capture dropped while full with no pop
        issue_i = 1'b1;
        step();
        issue_i = 1'b0;
        step();
        step();
        res_i = 8'h66;
        step();
        res_i = '0;
        check("drop_ovf", 32'(ovf_o), 32'd1);
        check("drop_err", 32'(err_o), 32'd1);
        check("drop_count", 32'(count_o), 32'd4);
        vals = '{8'h22, 8'h33, 8'h44, 8'h55};
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drop_contents", 32'(out_data_o), 32'(vals[i]));
            step();
        end
        out_ready_i = 1'b0;

        // reset with issues in flight; issue during reset is ignored
        reset_dut();
        issue_i = 1'b1;
        step();
        issue_i = 1'b0;
        step();
        step();
        issue_i = 1'b1;
        res_i   = 8'h77;
        step();
        res_i = '0;
        step();
        issue_i = 1'b0;
        check("mid_count", 32'(count_o), 32'd1);
        check("mid_inflight", 32'(inflight_o), 32'd2);
        rst     = 1'b1;
        issue_i = 1'b1;
        step();
        rst     = 1'b0;
        issue_i = 1'b0;
        check("mid_rst_count", 32'(count_o), 32'd0);
        check("mid_rst_inflight", 32'(inflight_o), 32'd0);
        check("mid_rst_can_issue", 32'(can_issue_o), 32'd1);
        repeat (5) step();
        check("mid_no_capture", 32'(count_o), 32'd0);

        // pop counter wrap
        reset_dut();
        issue_i     = 1'b1;
        out_ready_i = 1'b1;
        repeat (65535) step();
        issue_i = 1'b0;
        repeat (4) step();
        check("wrap_preload", 32'(pop_cnt_o), 32'hFFFF);
        check("wrap_drained", 32'(count_o), 32'd0);
        issue_i = 1'b1;
        step();
        issue_i = 1'b0;
        repeat (4) step();
        out_ready_i = 1'b0;
        check("wrap_zero", 32'(pop_cnt_o), 32'h0000);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
